// File: rtl/toast_mem_pkg.sv
// Shared constants and address-decode type for the data-memory responder.
// MMIO offsets are relative to the responder's MMIO_BASE parameter.
package toast_mem_pkg;

    localparam logic [11:0] CYCLE_LO_OFF = 12'h000;
    localparam logic [11:0] CYCLE_HI_OFF = 12'h004;
    localparam logic [11:0] TOHOST_OFF   = 12'h010;

    localparam int unsigned MMIO_WINDOW_BYTES = 4096;

    typedef enum logic [1:0] {
        RAM,
        MMIO,
        INVALID
    } dec_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: read-first, registered output, synchronous output clear.
// The array itself is never reset; only the output register is.
module dmem_ram #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clr_i,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_d;
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_d = mem_q[addr_i];
        if (clr_i) begin
            rdata_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Core data-memory responder: RAM, sticky address error and, with
// DMEM_MMIO_EN defined, an MMIO window holding a cycle counter and TOHOST.
module dmem_responder
    import toast_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [31:0] DMEM_addr,
    input  logic [31:0] DMEM_wr_data,
    input  logic        DMEM_wr_en,
    input  logic        DMEM_rst,
    output logic [31:0] DMEM_rd_data,
    output logic        Halt,
    output logic [31:0] Tohost_data,
    output logic        Addr_err
);

    localparam int unsigned AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

    dec_e        dec;
    logic        ram_sel_d, ram_sel_q;
    logic        err_d, err_q;
    logic [31:0] ram_rdata;
    logic [31:0] mmio_rdata;
    logic        unused_addr;

    assign unused_addr = ^DMEM_addr[1:0];

`ifdef DMEM_MMIO_EN
    localparam logic [31:0] WIN_MASK = ~(32'(MMIO_WINDOW_BYTES) - 32'd1);

    always_comb begin
        dec = INVALID;
        if (DMEM_addr < RAM_BYTES) begin
            dec = RAM;
        end else if ((DMEM_addr & WIN_MASK) == MMIO_BASE) begin
            dec = MMIO;
        end
    end
`else
    logic unused_base;

    assign unused_base = ^MMIO_BASE;

    always_comb begin
        dec = INVALID;
        if (DMEM_addr < RAM_BYTES) begin
            dec = RAM;
        end
    end
`endif

    dmem_ram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk_i  (Clk),
        .rst_ni (Reset_n),
        .clr_i  (DMEM_rst),
        .we_i   (DMEM_wr_en && (dec == RAM)),
        .addr_i (DMEM_addr[AW+1:2]),
        .wdata_i(DMEM_wr_data),
        .rdata_o(ram_rdata)
    );

    assign ram_sel_d = (dec == RAM);
    assign err_d     = err_q | (dec == INVALID);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ram_sel_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            ram_sel_q <= ram_sel_d;
            err_q     <= err_d;
        end
    end

    // Both read sources clear on DMEM_rst and reset, so the mux stays 0 then.
    assign DMEM_rd_data = ram_sel_q ? ram_rdata : mmio_rdata;
    assign Addr_err     = err_q;

`ifdef DMEM_MMIO_EN
    logic [63:0] cyc_d, cyc_q;
    logic [31:0] hi_d, hi_q;
    logic [31:0] tohost_d, tohost_q;
    logic [31:0] rd_d, rd_q;
    logic        halt_d, halt_q;
    logic [11:0] off;

    assign off = {DMEM_addr[11:2], 2'b00};

    always_comb begin
        cyc_d    = cyc_q + 64'd1;
        hi_d     = hi_q;
        tohost_d = tohost_q;
        halt_d   = halt_q;
        rd_d     = '0;
        if (dec == MMIO) begin
            unique case (1'b1)
                (off == CYCLE_LO_OFF): begin
                    rd_d = cyc_q[31:0];
                    hi_d = cyc_q[63:32];
                end
                (off == CYCLE_HI_OFF): rd_d = hi_q;
                (off == TOHOST_OFF): begin
                    rd_d = tohost_q;
                    if (DMEM_wr_en) begin
                        tohost_d = DMEM_wr_data;
                        halt_d   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
        if (DMEM_rst) begin
            rd_d = '0;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cyc_q    <= '0;
            hi_q     <= '0;
            tohost_q <= '0;
            rd_q     <= '0;
            halt_q   <= 1'b0;
        end else begin
            cyc_q    <= cyc_d;
            hi_q     <= hi_d;
            tohost_q <= tohost_d;
            rd_q     <= rd_d;
            halt_q   <= halt_d;
        end
    end

    assign mmio_rdata  = rd_q;
    assign Halt        = halt_q;
    assign Tohost_data = tohost_q;
`else
    assign mmio_rdata  = '0;
    assign Halt        = 1'b0;
    assign Tohost_data = '0;
`endif

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: RAM depth in 32-bit words; power of two.
REQ-002 Parameter MMIO_BASE, default 32'h8000_0000: base byte address of the MMIO window; 4 KiB aligned.
REQ-003 Clk  input  1  sole clock; all state on rising edge.
REQ-004 Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 DMEM_addr  input  32  byte address from core; bits [1:0] ignored (word granular).
REQ-006 DMEM_wr_data  input  32  store data, full word.
REQ-007 DMEM_wr_en  input  1  store strobe, one word per cycle while high.
REQ-008 DMEM_rst  input  1  synchronous clear of the read-data register.
REQ-009 DMEM_rd_data  output  32  registered read data.
REQ-010 Halt  output  1  sticky; set by a write to TOHOST.
REQ-011 Tohost_data  output  32  last value written to TOHOST.
REQ-012 Addr_err  output  1  sticky; set by any access outside RAM and MMIO ranges.

Function
REQ-013 RAM range: byte addresses 0 .. 4*DEPTH_WORDS-1, indexed by DMEM_addr[log2(DEPTH_WORDS)+1:2].
REQ-014 Read latency: exactly 1 cycle; DMEM_rd_data updates every cycle from the address sampled on the previous edge, independent of DMEM_wr_en.
REQ-015 Read-during-write, same word: DMEM_rd_data returns the old contents (read-first); new data visible from the following access.
REQ-016 Write: when DMEM_wr_en=1 at an edge, the addressed RAM word takes DMEM_wr_data at that edge.
REQ-017 DMEM_rst=1 at an edge: DMEM_rd_data becomes 0 for that cycle; RAM contents unchanged; a simultaneous write still completes.
REQ-018 Out-of-range read: DMEM_rd_data=0, Addr_err set. Out-of-range write: discarded, Addr_err set.
REQ-019 Cycle counter: 64-bit, increments by 1 every cycle after reset release, wraps 2^64-1 -> 0 silently.
REQ-020 MMIO map (offset from MMIO_BASE): 0x000 CYCLE_LO (R), 0x004 CYCLE_HI (R), 0x010 TOHOST (R/W); other offsets in the 4 KiB window read 0, ignore writes, do not set Addr_err.
REQ-021 CYCLE_HI read returns the upper half latched at the most recent CYCLE_LO read, so LO-then-HI is coherent across a carry.
REQ-022 Writes to CYCLE_LO/CYCLE_HI are ignored.
REQ-023 TOHOST write: Tohost_data loads DMEM_wr_data and Halt sets on the same edge; later TOHOST writes update Tohost_data; Halt stays set.
REQ-024 Halt does not gate RAM or counter activity.

Reset
REQ-025 Reset_n low asynchronously clears DMEM_rd_data, cycle counter, CYCLE_HI latch, Tohost_data, Halt and Addr_err to 0.
REQ-026 RAM array is not reset; contents are undefined after power-up and preserved across reset.
REQ-027 Reset asserted mid-write: the write is not guaranteed; all other state is cleared.

Configuration
REQ-028 Macro DMEM_MMIO_EN defined: MMIO window, cycle counter, Halt and Tohost_data behave as in REQ-019..REQ-024.
REQ-029 DMEM_MMIO_EN undefined: no counter or MMIO logic; MMIO-range accesses are out-of-range per REQ-018; Halt and Tohost_data tied to 0.

Structure
REQ-030 Shared package toast_mem_pkg holds MMIO offset constants (CYCLE_LO, CYCLE_HI, TOHOST), window size and the address-decode enum {RAM, MMIO, INVALID}.
REQ-031 Storage lives in sub-module dmem_ram (single-port, read-first, registered output, synchronous clear input); dmem_responder holds decode, MMIO and flags.

Verification
REQ-032 Write 32'hDEAD_BEEF to 0x0000_0010, read 0x0000_0010 next cycle -> DMEM_rd_data=32'hDEAD_BEEF one cycle after the read address.
REQ-033 Same-cycle write 32'h1111_1111 and read to 0x20 holding 32'h2222_2222 -> rd_data=32'h2222_2222; re-read -> 32'h1111_1111.
REQ-034 Read 0x0000_0010 with DMEM_rst=1 -> rd_data=0 next cycle; re-read without DMEM_rst -> stored value.
REQ-035 Counter forced to 32'hFFFF_FFFF low half, read CYCLE_LO then CYCLE_HI -> HI equals value latched with LO, not post-carry value.
REQ-036 Write 32'h0000_0001 to MMIO_BASE+0x10 -> Halt=1, Tohost_data=1 next cycle; Reset_n pulse -> both 0.
REQ-037 Read 0x4000_0000 -> rd_data=0, Addr_err=1 and stays 1 until Reset_n low.
